// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read side: state encoding,
// default geometry and the hardwired-zero register address.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS   = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  // Register 0 always reads as zero and is never a bypass target
  localparam int ZERO_REG = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_read_port_if.sv
// Request/response bus of the register-file read port.
// The master issues requests and consumes responses; the slave is the read port.
// With REGFILE_READ_PARITY_EN defined the response also carries rsp_parity.
interface regfile_read_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_scan;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
`ifdef REGFILE_READ_PARITY_EN
  logic                  rsp_parity;

  modport master (
    output req_valid, req_addr, req_scan, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_parity
  );

  modport slave (
    input  req_valid, req_addr, req_scan, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_parity
  );
`else
  modport master (
    output req_valid, req_addr, req_scan, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_scan, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
  );
`endif

endinterface

// File: rtl/regfile_read_mux.sv
// Combinational read value for one address: bank select, hardwired zero
// register, write-to-read bypass, and zero for addresses beyond the bank.
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_contents,
  input  logic                           wr_enable,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic [DATA_WIDTH-1:0]          data
);

  logic [DATA_WIDTH-1:0] bank_val;
  logic                  in_range;
  logic                  is_zero;
  logic                  bypass;

  // Pick the addressed register out of the flattened bank; unmatched addresses stay out of range
  always_comb begin
    bank_val = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        bank_val = reg_contents[i*DATA_WIDTH +: DATA_WIDTH];
        in_range = 1'b1;
      end
    end
  end

  assign is_zero = (addr == ADDR_WIDTH'(ZERO_REG));
  assign bypass  = wr_enable && (wr_addr == addr);

  // Zero register and out-of-range win over bypass, bypass wins over stored contents
  always_comb begin
    data = bank_val;
    if (!in_range || is_zero) begin
      data = '0;
    end else if (bypass) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/regfile_read_port.sv
// Read-side controller for the register bank: single reads and full-bank
// scans over a valid/ready handshake, with a single registered response slot.
// Optional macro REGFILE_READ_PARITY_EN adds rsp_parity (XOR of rsp_data).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_contents,
  input  logic                           wr_enable,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  regfile_read_port_if.slave             bus,
  output logic                           busy
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  slot_free;
  logic                  accept;
  logic                  load_single;
  logic                  load_scan;
  logic                  scan_last;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // The response slot can take new data when empty or when being consumed this cycle
  assign slot_free     = !bus.rsp_valid || bus.rsp_ready;
  assign bus.req_ready = (state == IDLE) && slot_free;
  assign accept        = bus.req_valid && bus.req_ready;
  assign load_single   = accept && !bus.req_scan;
  assign load_scan     = (state == SCAN) && slot_free;
  assign scan_last     = (cnt == ADDR_WIDTH'(NUM_REGS - 1));
  assign sel_addr      = (state == SCAN) ? cnt : bus.req_addr;
  assign busy          = (state != IDLE) || bus.rsp_valid;

  regfile_read_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mux (
    .addr         (sel_addr),
    .reg_contents (reg_contents),
    .wr_enable    (wr_enable),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .data         (sel_data)
  );

  // Scan sequencing and the response register; data is captured once and held until consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_addr  <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_last  <= 1'b0;
`ifdef REGFILE_READ_PARITY_EN
      bus.rsp_parity <= 1'b0;
`endif
    end else begin
      if (load_single || load_scan) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_addr  <= sel_addr;
        bus.rsp_data  <= sel_data;
        bus.rsp_last  <= load_single || scan_last;
`ifdef REGFILE_READ_PARITY_EN
        bus.rsp_parity <= ^sel_data;
`endif
      end else if (slot_free) begin
        bus.rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept && bus.req_scan) begin
            state <= SCAN;
            cnt   <= '0;
          end
        end
        SCAN: begin
          if (slot_free) begin
            if (scan_last) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_regfile_read_port;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR*DW-1:0] reg_contents;
  logic            wr_enable;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy;
  logic [DW-1:0]   bank [NR];

  // Reference model: one response slot plus a queue of addresses still to be scanned
  logic            m_valid = 1'b0;
  logic [AW-1:0]   m_addr  = '0;
  logic [DW-1:0]   m_data  = '0;
  logic            m_last  = 1'b0;
  int              scan_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  regfile_read_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  regfile_read_port #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .reg_contents (reg_contents),
    .wr_enable    (wr_enable),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .bus          (bus),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Flatten the bench-side register bank onto the DUT input
  always_comb begin
    reg_contents = '0;
    for (int i = 0; i < NR; i++) reg_contents[i*DW +: DW] = bank[i];
  end

  function automatic logic [DW-1:0] ref_value(input int a);
    if (a == 0) return '0;
    if (wr_enable && int'(wr_addr) == a) return wr_data;
    return bank[a];
  endfunction

  function automatic logic exp_ready();
    return (scan_q.size() == 0) && (!m_valid || bus.rsp_ready);
  endfunction

  function automatic logic exp_busy();
    return (scan_q.size() != 0) || m_valid;
  endfunction

  // Advance the model on the current inputs, then step the DUT one edge
  task automatic tick();
    logic          n_valid;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_data;
    logic          n_last;
    logic          slot;
    int            a;
    n_valid = m_valid; n_addr = m_addr; n_data = m_data; n_last = m_last;
    slot = !m_valid || bus.rsp_ready;
    if (reset) begin
      n_valid = 1'b0; n_addr = '0; n_data = '0; n_last = 1'b0;
      scan_q.delete();
    end else if (scan_q.size() == 0 && slot && bus.req_valid) begin
      if (bus.req_scan) begin
        for (int i = 0; i < NR; i++) scan_q.push_back(i);
        n_valid = 1'b0;
      end else begin
        n_valid = 1'b1; n_addr = bus.req_addr;
        n_data = ref_value(int'(bus.req_addr)); n_last = 1'b1;
      end
    end else if (scan_q.size() != 0 && slot) begin
      a = scan_q.pop_front();
      n_valid = 1'b1; n_addr = AW'(a); n_data = ref_value(a);
      n_last = (scan_q.size() == 0);
    end else if (slot) begin
      n_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    m_valid = n_valid; m_addr = n_addr; m_data = n_data; m_last = n_last;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_scan = 1'b0; bus.req_addr = '0;
    bus.rsp_ready = 1'b1; wr_enable = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) bank[i] = '0;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_compared++; if (bus.rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_compared++; if (bus.req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_compared++; if (bus.rsp_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    n_compared++; if (bus.rsp_last !== 1'b0 || bus.rsp_addr !== 5'd0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_addr_last: got %0d/%b want 0/0", bus.rsp_addr, bus.rsp_last); end
  endtask

  task automatic test_single_read();
    bank[3] = 32'hDEADBEEF;
    bus.req_valid = 1'b1; bus.req_addr = 5'd3; bus.req_scan = 1'b0; bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    #1;
    n_compared++; if (bus.rsp_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_valid: got %b want 1", bus.rsp_valid); end
    n_compared++; if (bus.rsp_addr !== 5'd3) begin n_mismatched++; $display("[TB] FAIL single_addr: got %0d want 3", bus.rsp_addr); end
    n_compared++; if (bus.rsp_data !== 32'hDEADBEEF) begin n_mismatched++; $display("[TB] FAIL single_data: got %h want deadbeef", bus.rsp_data); end
    n_compared++; if (bus.rsp_last !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_last: got %b want 1", bus.rsp_last); end
    bank[0] = 32'hFFFFFFFF;
    bus.req_valid = 1'b1; bus.req_addr = 5'd0;
    tick();
    bus.req_valid = 1'b0;
    #1;
    n_compared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== 5'd0) begin n_mismatched++; $display("[TB] FAIL zero_valid_addr: got %b/%0d want 1/0", bus.rsp_valid, bus.rsp_addr); end
    n_compared++; if (bus.rsp_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL zero_data: got %h want 0", bus.rsp_data); end
    tick();
  endtask

  task automatic test_bypass();
    bank[5] = '0;
    wr_enable = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
    bus.req_valid = 1'b1; bus.req_addr = 5'd5;
    tick();
    bank[5] = 32'h12345678;
    bus.req_valid = 1'b0; wr_enable = 1'b0;
    #1;
    n_compared++; if (bus.rsp_data !== 32'h12345678) begin n_mismatched++; $display("[TB] FAIL bypass_data: got %h want 12345678", bus.rsp_data); end
    wr_enable = 1'b1; wr_addr = 5'd0; wr_data = 32'hCAFEF00D;
    bus.req_valid = 1'b1; bus.req_addr = 5'd0;
    tick();
    bus.req_valid = 1'b0; wr_enable = 1'b0;
    #1;
    n_compared++; if (bus.rsp_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL bypass_zero: got %h want 0", bus.rsp_data); end
    tick();
  endtask

  task automatic test_hold();
    logic [DW-1:0] orig;
    orig = 32'hA5A5_0707;
    bank[7] = orig;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 5'd7;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_enable = 1'b1; wr_addr = 5'd7; wr_data = $urandom;
      #1;
      n_compared++; if (bus.req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_req_ready: got %b want 0", bus.req_ready); end
      tick();
      bank[7] = wr_data;
      n_compared++; if (bus.rsp_data !== orig || bus.rsp_addr !== 5'd7) begin n_mismatched++; $display("[TB] FAIL hold_data: got %h@%0d want %h@7", bus.rsp_data, bus.rsp_addr, orig); end
    end
    wr_enable = 1'b0;
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 5'd3;
    #1;
    n_compared++; if (bus.req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_req_ready: got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    #1;
    n_compared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== 5'd3 || bus.rsp_data !== 32'hDEADBEEF) begin n_mismatched++; $display("[TB] FAIL release_next: got %b %0d %h want 1 3 deadbeef", bus.rsp_valid, bus.rsp_addr, bus.rsp_data); end
    tick();
  endtask

  task automatic test_scan();
    int seen;
    logic [DW-1:0] want;
    for (int i = 0; i < NR; i++) bank[i] = i * 32'h0101;
    bank[0] = 32'hFFFFFFFF;
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_scan = 1'b1;
    tick();
    bus.req_valid = 1'b0; bus.req_scan = 1'b0;
    #1;
    n_compared++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL scan_accept: got valid %b busy %b want 0 1", bus.rsp_valid, busy); end
    seen = 0;
    for (int cyc = 0; cyc < 200 && seen < NR; cyc++) begin
      bus.rsp_ready = (cyc % 2 == 0);
      #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        want = (seen == 0) ? 32'h0 : seen * 32'h0101;
        n_compared++; if (bus.rsp_addr !== AW'(seen) || bus.rsp_data !== want || bus.rsp_last !== (seen == NR - 1)) begin n_mismatched++; $display("[TB] FAIL scan_rsp: got %0d %h %b want %0d %h %b", bus.rsp_addr, bus.rsp_data, bus.rsp_last, seen, want, (seen == NR - 1)); end
        seen++;
      end
      tick();
    end
    n_compared++; if (seen !== NR) begin n_mismatched++; $display("[TB] FAIL scan_count: got %0d want %0d", seen, NR); end
    bus.rsp_ready = 1'b1;
    #1;
    n_compared++; if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL scan_done: got busy %b ready %b want 0 1", busy, bus.req_ready); end
  endtask

  task automatic test_scan_reset();
    int cnt;
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_scan = 1'b1;
    tick();
    bus.req_valid = 1'b0; bus.req_scan = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (bus.rsp_valid) cnt++;
      if (cnt == 10) break;
      tick();
    end
    n_compared++; if (cnt !== 10 || bus.rsp_addr !== 5'd9) begin n_mismatched++; $display("[TB] FAIL scan10: got count %0d addr %0d want 10 9", cnt, bus.rsp_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_compared++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL scan_abort: got valid %b busy %b ready %b want 0 0 1", bus.rsp_valid, busy, bus.req_ready); end
    bank[2] = 32'h0BAD_C0DE;
    bus.req_valid = 1'b1; bus.req_addr = 5'd2;
    tick();
    bus.req_valid = 1'b0;
    #1;
    n_compared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== 5'd2 || bus.rsp_data !== 32'h0BAD_C0DE || bus.rsp_last !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_abort_read: got %b %0d %h %b want 1 2 0badc0de 1", bus.rsp_valid, bus.rsp_addr, bus.rsp_data, bus.rsp_last); end
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_scan  = ($urandom_range(0, 15) == 0);
      bus.req_addr  = AW'($urandom_range(0, NR - 1));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      wr_enable     = 1'($urandom_range(0, 1));
      wr_addr       = AW'($urandom_range(0, NR - 1));
      wr_data       = $urandom;
      if ($urandom_range(0, 3) == 0) bank[$urandom_range(0, NR - 1)] = $urandom;
      #1;
      n_compared++; if (bus.rsp_valid !== m_valid) begin n_mismatched++; $display("[TB] FAIL rand_valid cyc %0d: got %b want %b", cyc, bus.rsp_valid, m_valid); end
      if (m_valid) begin
        n_compared++; if (bus.rsp_addr !== m_addr || bus.rsp_data !== m_data || bus.rsp_last !== m_last) begin n_mismatched++; $display("[TB] FAIL rand_rsp cyc %0d: got %0d %h %b want %0d %h %b", cyc, bus.rsp_addr, bus.rsp_data, bus.rsp_last, m_addr, m_data, m_last); end
`ifdef REGFILE_READ_PARITY_EN
        n_compared++; if (bus.rsp_parity !== ^m_data) begin n_mismatched++; $display("[TB] FAIL rand_parity cyc %0d: got %b want %b", cyc, bus.rsp_parity, ^m_data); end
`endif
      end
      n_compared++; if (bus.req_ready !== exp_ready()) begin n_mismatched++; $display("[TB] FAIL rand_req_ready cyc %0d: got %b want %b", cyc, bus.req_ready, exp_ready()); end
      n_compared++; if (busy !== exp_busy()) begin n_mismatched++; $display("[TB] FAIL rand_busy cyc %0d: got %b want %b", cyc, busy, exp_busy()); end
      tick();
    end
    idle_inputs();
    for (int cyc = 0; cyc < 80 && exp_busy(); cyc++) tick();
    #1;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rand_drain: got busy %b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_bypass();
    test_hold();
    test_scan();
    test_scan_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
